clk_div_ctrl: RTL and testbench
===============================

# clk_div_ctrl

Parametrised, runtime-programmable clock divider with halt and single-step control, used to derive the slow processor clock for the single-cycle MIPS core on the Nexys4 DDR board. Generates a 50 % duty square output plus one-cycle rise/fall strobes in the `clk_in` domain. The half-period is reloadable without glitches, and the output can be halted or stepped one period at a time for board-level debug.

## Interface

Parameters:
- `DIV_W` = 16: width of the half-period count.
- `DIV_DEFAULT` = 2: half-period in `clk_in` cycles after reset. A value of 0 is treated as 1.

Ports:
- `clk_in`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `half_per`  in  DIV_W  requested half-period in `clk_in` cycles. 0 is treated as 1.
- `load`  in  1  single-cycle strobe that captures `half_per` as the pending value.
- `run`  in  1  1 = free-run; 0 = halt with `clk_out` low.
- `step`  in  1  synchronous, already-debounced step request. Present only with `CLKDIV_STEP_EN`.
- `clk_out`  out  1  divided clock, registered.
- `rise_tick`  out  1  high for the single cycle in which `clk_out` first reads 1 in a high phase.
- `fall_tick`  out  1  high for the single cycle in which `clk_out` first reads 0 after a high phase.
- `active_div`  out  DIV_W  half-period currently applied, with 0 shown as 1.
- `halted`  out  1  1 while in HALTED.

## Operation

- **Counter and boundary.** Counter `cnt` counts against effective half-period `H` = max(act, 1). A boundary occurs when `cnt == H-1`. At a boundary: `clk_out` toggles and `cnt` clears to 0.
- **Load.**
  - `load` stores `half_per` into a pending register and sets the pending flag.
  - A later `load` before the boundary overwrites the pending value (last write wins).
  - The pending value is applied at the next boundary, including a boundary in the same cycle as `load`. At that boundary `active_div` updates and the pending flag clears.
  - A phase already in progress is never shortened or lengthened.
- **States.**
  - **HALTED**
    - `cnt` = 0 and `clk_out` = 0.
    - `run` = 1 moves to RUN.
    - A rising edge on `step`, with `run` = 0, moves to STEP.
  - **RUN**
    - Counts and toggles at each boundary.
    - `run` = 0 while `clk_out` = 0: go to HALTED on the next edge and clear `cnt`.
    - `run` = 0 while `clk_out` = 1: go to DRAIN.
  - **DRAIN**
    - Completes the current high phase at its full length.
    - At the falling boundary: `fall_tick` pulses and the state moves to HALTED.
    - `run` returning to 1 during DRAIN moves back to RUN with no change to counting.
  - **STEP**
    - Runs exactly one period: a low phase of H, then a high phase of H.
    - At the fall it returns to HALTED, or to RUN if `run` = 1 at that point.
    - `step` is ignored outside HALTED.
- **Step detection.** The `step` edge detector is a registered previous-value flop. A `step` held high produces one step only.
- **Pending load while halted.** A load pending while HALTED is applied on the cycle that HALTED is exited, so the first phase already uses the new value.

## Timing

- **Reset values** (asserted asynchronously by `rst_n` = 0):
  - `clk_out` = 0, `rise_tick` = 0, `fall_tick` = 0.
  - `halted` = 1, state HALTED.
  - `cnt` = 0, pending flag cleared.
  - `active_div` = `DIV_DEFAULT`, shown as 1 if `DIV_DEFAULT` is 0.
- **Reset mid-phase.** `clk_out` drops to 0 immediately; no `fall_tick` is generated.
- **First rise.** Edge E samples `run` = 1 (HALTED to RUN, `cnt` = 0). The first rising boundary is edge E+H.
- **Steady state.** Period is 2·H cycles at 50 % duty. `rise_tick` and `fall_tick` each occur once per period and are coincident with the `clk_out` transition.
- **Halting.** `halted` rises one edge after entering HALTED, or one edge after the fall completing DRAIN.
- **Minimum H = 1.** `clk_out` toggles every cycle; `rise_tick` and `fall_tick` alternate every cycle.

## Configuration

- **`CLKDIV_STEP_EN` defined:** the `step` port, the edge detector and the STEP state are compiled in.
- **`CLKDIV_STEP_EN` undefined:**
  - The `step` port does not exist and STEP is unreachable and not synthesised.
  - HALTED is exited only via `run` = 1.
  - All other behaviour is identical.

## Test plan

- **Reset default run:** reset, `run` = 1, no load → `clk_out` period 4 with 2 high / 2 low; `rise_tick` every 4 cycles; `active_div` = 2.
- **Load mid-phase:** `load` `half_per` = 5 during a high phase → that phase ends at 2 cycles; `active_div` becomes 5 at that boundary; later periods are 10 cycles; no glitch.
- **Zero half-period:** `load` `half_per` = 0 → `active_div` = 1; `clk_out` toggles every cycle with period 2.
- **Halt mid-high:** `run` dropped one cycle into a high phase with H = 4 → high lasts 4 cycles in total; one `fall_tick`; then `halted` = 1 and `clk_out` stays 0 for 20+ cycles.
- **Single step** (`CLKDIV_STEP_EN`): halted with H = 3, one `step` pulse → 3 low then 3 high cycles; exactly one `rise_tick` and one `fall_tick`; back to HALTED. Holding `step` high gives no second period. `step` while running has no effect.
- **Async reset mid-operation:** `rst_n` low mid-high with a pending load → `clk_out` = 0 at once without waiting for `clk_in`; after release, `active_div` = `DIV_DEFAULT` and the pending load is discarded.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - programmable clock divider with halt/drain and optional single-step (CLKDIV_STEP_EN)
module clk_div_ctrl #(
  parameter int DIV_W       = 16,
  parameter int DIV_DEFAULT = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] half_per,
  input  logic             load,
  input  logic             run,
`ifdef CLKDIV_STEP_EN
  input  logic             step,
`endif
  output logic             clk_out,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [DIV_W-1:0] active_div,
  output logic             halted
);

  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0] DEF_RAW = DIV_W'(DIV_DEFAULT);
  localparam logic [DIV_W-1:0] DEF_EFF = (DEF_RAW == '0) ? ONE : DEF_RAW;

  typedef enum logic [1:0] {
    S_HALTED = 2'd0,
    S_RUN    = 2'd1,
`ifdef CLKDIV_STEP_EN
    S_STEP   = 2'd3,
`endif
    S_DRAIN  = 2'd2
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] pend_val;
  logic             pend_flag;

  logic             leave_halt;
  logic             stop_low;
  logic             boundary;
  logic             apply;

  // A zero half-period is held as 1 so active_div and the compare agree.
  function automatic logic [DIV_W-1:0] norm(input logic [DIV_W-1:0] v);
    return (v == '0) ? ONE : v;
  endfunction

`ifdef CLKDIV_STEP_EN
  logic step_q;
  logic step_rise;

  assign step_rise  = step & ~step_q;
  assign leave_halt = (state == S_HALTED) && (run || step_rise);

  // Previous-value flop for step edge detection; a held step yields one edge.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end
`else
  assign leave_halt = (state == S_HALTED) && run;
`endif

  // Run dropped during a low phase stops immediately without a rise.
  assign stop_low = ((state == S_RUN) || (state == S_DRAIN)) && !run && !clk_out;
  assign boundary = (state != S_HALTED) && !stop_low && (cnt == active_div - ONE);
  // New half-periods only take effect between phases or when leaving HALTED.
  assign apply    = leave_halt || boundary;

  // Pending half-period capture and application at phase boundaries.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      active_div <= DEF_EFF;
      pend_val   <= '0;
      pend_flag  <= 1'b0;
    end else if (apply) begin
      if (load) begin
        active_div <= norm(half_per);
      end else if (pend_flag) begin
        active_div <= norm(pend_val);
      end
      pend_flag <= 1'b0;
    end else if (load) begin
      pend_val  <= half_per;
      pend_flag <= 1'b1;
    end
  end

  // Control FSM: phase counter, divided clock, strobes and halted flag.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_HALTED;
      cnt       <= '0;
      clk_out   <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
      halted    <= 1'b1;
    end else begin
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
      halted    <= (state == S_HALTED) && !leave_halt;

      case (state)
        S_HALTED: begin
          cnt     <= '0;
          clk_out <= 1'b0;
          if (run) begin
            state <= S_RUN;
`ifdef CLKDIV_STEP_EN
          end else if (step_rise) begin
            state <= S_STEP;
`endif
          end
        end

        S_RUN, S_DRAIN: begin
          if (stop_low) begin
            state <= S_HALTED;
            cnt   <= '0;
          end else if (boundary) begin
            cnt       <= '0;
            clk_out   <= ~clk_out;
            rise_tick <= ~clk_out;
            fall_tick <= clk_out;
            // A falling boundary with run low completes the drain.
            state     <= (!run && clk_out) ? S_HALTED : S_RUN;
          end else begin
            cnt   <= cnt + ONE;
            state <= run ? S_RUN : S_DRAIN;
          end
        end

`ifdef CLKDIV_STEP_EN
        S_STEP: begin
          if (boundary) begin
            cnt       <= '0;
            clk_out   <= ~clk_out;
            rise_tick <= ~clk_out;
            fall_tick <= clk_out;
            // One full period done once the high phase ends.
            if (clk_out) begin
              state <= run ? S_RUN : S_HALTED;
            end
          end else begin
            cnt <= cnt + ONE;
          end
        end
`endif

        default: begin
          state   <= S_HALTED;
          cnt     <= '0;
          clk_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - directed scoreboard bench for clk_div_ctrl
module tb_clk_div_ctrl;

  logic        clk_in;
  logic        rst_n;
  logic [15:0] half_per;
  logic        load;
  logic        run;
`ifdef CLKDIV_STEP_EN
  logic        step;
`endif
  logic        clk_out;
  logic        rise_tick;
  logic        fall_tick;
  logic [15:0] active_div;
  logic        halted;

  typedef struct {
    bit rise;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t ev;
  int  cyc     = 0;
  int  n_check = 0;
  int  n_fail  = 0;
  int  e, b, c, d, f;

  clk_div_ctrl #(.DIV_W(16), .DIV_DEFAULT(2)) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .half_per   (half_per),
    .load       (load),
    .run        (run),
`ifdef CLKDIV_STEP_EN
    .step       (step),
`endif
    .clk_out    (clk_out),
    .rise_tick  (rise_tick),
    .fall_tick  (fall_tick),
    .active_div (active_div),
    .halted     (halted)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_check++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_ev(input bit rise, input int at);
    exp_q.push_back('{rise: rise, cyc: at});
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk_in);
  endtask

  // Scoreboard: every tick seen must match the next expected tick and cycle.
  always @(negedge clk_in) begin
    if (rst_n === 1'b1 && (rise_tick || fall_tick)) begin
      check("tick_expected", (exp_q.size() != 0), 1);
      check("tick_not_both", (rise_tick && fall_tick), 0);
      if (exp_q.size() != 0) begin
        ev = exp_q.pop_front();
        check("tick_kind_rise", rise_tick, ev.rise);
        check("tick_cycle", cyc, ev.cyc);
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    run      = 1'b0;
    load     = 1'b0;
    half_per = '0;
`ifdef CLKDIV_STEP_EN
    step     = 1'b0;
`endif
    @(negedge clk_in);
    @(negedge clk_in);
    check("rst_clk_out", clk_out, 0);
    check("rst_rise", rise_tick, 0);
    check("rst_fall", fall_tick, 0);
    check("rst_halted", halted, 1);
    check("rst_active_div", active_div, 2);
    rst_n = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    check("idle_halted", halted, 1);
    check("idle_clk_out", clk_out, 0);

    // Default run, H = 2, then load 5 during a high phase
    e = cyc + 1;
    run = 1'b1;
    push_ev(1, e + 2);  push_ev(0, e + 4);
    push_ev(1, e + 6);  push_ev(0, e + 8);
    push_ev(1, e + 10); push_ev(0, e + 12);
    push_ev(1, e + 14); push_ev(0, e + 16);
    push_ev(1, e + 21); push_ev(0, e + 26);
    push_ev(1, e + 31); push_ev(0, e + 36);
    wait_until(e + 1); check("run_halted_clear", halted, 0);
    wait_until(e + 2); check("run_high0", clk_out, 1);
    wait_until(e + 3); check("run_high1", clk_out, 1);
    wait_until(e + 4); check("run_low0", clk_out, 0);
    wait_until(e + 5); check("run_low1", clk_out, 0);
    check("run_active_div", active_div, 2);
    wait_until(e + 14);
    load = 1'b1; half_per = 16'd5;
    @(negedge clk_in);
    load = 1'b0;
    check("load_pending_div", active_div, 2);
    wait_until(e + 16);
    check("load_applied_div", active_div, 5);
    check("load_fall_clk", clk_out, 0);
    wait_until(e + 20); check("load_low5", clk_out, 0);
    wait_until(e + 21); check("load_rise5", clk_out, 1);

    // Zero half-period behaves as 1
    wait_until(e + 36);
    b = cyc;
    load = 1'b1; half_per = 16'd0;
    @(negedge clk_in);
    load = 1'b0;
    check("zero_pending_div", active_div, 5);
    push_ev(1, b + 5); push_ev(0, b + 6);
    push_ev(1, b + 7); push_ev(0, b + 8);
    push_ev(1, b + 9); push_ev(0, b + 10);
    wait_until(b + 5); check("zero_div", active_div, 1); check("zero_high", clk_out, 1);
    wait_until(b + 6); check("zero_low", clk_out, 0);

    // Load 4 on a boundary, drop run one cycle into that high phase
    wait_until(b + 10);
    load = 1'b1; half_per = 16'd4;
    push_ev(1, b + 11); push_ev(0, b + 15);
    @(negedge clk_in);
    load = 1'b0; run = 1'b0;
    check("drain_div", active_div, 4);
    check("drain_high_start", clk_out, 1);
    wait_until(b + 14); check("drain_high_end", clk_out, 1);
    wait_until(b + 15); check("drain_fell", clk_out, 0); check("drain_halted_lag", halted, 0);
    @(negedge clk_in);
    check("drain_halted", halted, 1);
    repeat (22) begin
      @(negedge clk_in);
      check("halt_idle_clk", clk_out, 0);
    end

    // Load while halted stays pending until HALTED is exited
    load = 1'b1; half_per = 16'd3;
    @(negedge clk_in);
    load = 1'b0;
    check("halt_pend_div", active_div, 4);
    check("halt_pend_halted", halted, 1);

`ifdef CLKDIV_STEP_EN
    c = cyc;
    step = 1'b1;
    push_ev(1, c + 4); push_ev(0, c + 7);
    wait_until(c + 1); check("step_div", active_div, 3); check("step_halted", halted, 0);
    wait_until(c + 3); check("step_low", clk_out, 0);
    wait_until(c + 4); check("step_rise", clk_out, 1);
    wait_until(c + 6); check("step_high", clk_out, 1);
    wait_until(c + 7); check("step_fall", clk_out, 0);
    wait_until(c + 8); check("step_rehalted", halted, 1);
    repeat (10) @(negedge clk_in);
    check("step_held_clk", clk_out, 0);
    check("step_held_halted", halted, 1);
    step = 1'b0;
    @(negedge clk_in);
`endif

    // Resume with H = 3; step while running is ignored
    d = cyc;
    run = 1'b1;
    push_ev(1, d + 4); push_ev(0, d + 7); push_ev(1, d + 10);
    wait_until(d + 1); check("resume_div", active_div, 3); check("resume_halted", halted, 0);
`ifdef CLKDIV_STEP_EN
    wait_until(d + 2);
    step = 1'b1;
    @(negedge clk_in);
    step = 1'b0;
`endif
    wait_until(d + 10);
    load = 1'b1; half_per = 16'd9;
    @(negedge clk_in);
    load = 1'b0;
    check("pre_reset_high", clk_out, 1);

    // Asynchronous reset mid-high with a pending load
    #2;
    rst_n = 1'b0;
    run = 1'b0;
    #1;
    check("async_clk_out", clk_out, 0);
    check("async_halted", halted, 1);
    check("async_div", active_div, 2);
    @(negedge clk_in);
    rst_n = 1'b1;
    @(negedge clk_in);
    check("post_reset_div", active_div, 2);
    check("post_reset_clk", clk_out, 0);
    f = cyc;
    run = 1'b1;
    push_ev(1, f + 3); push_ev(0, f + 5);
    wait_until(f + 5);
    check("discard_pend_div", active_div, 2);
    wait_until(f + 6);
    check("missing_ticks", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule
